// File: rtl/pc_pkg.sv
// Shared opcode type and default sizing for the RAT CPU program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JMP  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_INTR = 3'd5,
        PC_RST  = 3'd6,
        PC_RSVD = 3'd7
    } pc_op_t;

    localparam int PC_ADDR_W_DEF    = 10;
    localparam int PC_STK_DEPTH_DEF = 8;

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// Return-address LIFO: registered fill level over an unreset storage array.
// Pushes while full and pops while empty are silently dropped.
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_m1_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             full_s;
    logic             empty_s;

    assign full_s     = (level_r == LVL_W'(DEPTH));
    assign empty_s    = (level_r == {LVL_W{1'b0}});
    assign level_m1_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
    // Level never exceeds DEPTH-1 when indexing, so the narrow slices are lossless.
    assign wr_idx_s   = level_r[IDX_W-1:0];
    assign rd_idx_s   = level_m1_s[IDX_W-1:0];

    // Fill-level counter; clear has priority over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {LVL_W{1'b0}};
        end else if (clr) begin
            level_r <= {LVL_W{1'b0}};
        end else if (push && !full_s) begin
            level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        end else if (pop && !empty_s) begin
            level_r <= level_m1_s;
        end else begin
            level_r <= level_r;
        end
    end

    // Entry storage; contents are don't-care above the level so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !full_s && !clr) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Top-of-stack view, forced to zero when nothing is stored.
    always_comb begin
        top = {WIDTH{1'b0}};
        if (empty_s) begin
            top = {WIDTH{1'b0}};
        end else begin
            top = mem_r[rd_idx_s];
        end
    end

    assign level = level_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC mux, op decode, sticky stack-error flag
// and an internal return-address stack for CALL/RET/INTR.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W_DEF,
    parameter int                STK_DEPTH = PC_STK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] INTR_VEC  = ADDR_W'(10'h3FF),
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(10'h000)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  pc_op_t                         pc_op,
    input  logic [ADDR_W-1:0]              from_immed,
    input  logic                           clr_err,
    output logic [ADDR_W-1:0]              pc_count,
    output logic [ADDR_W-1:0]              stk_top,
    output logic [$clog2(STK_DEPTH+1)-1:0] stk_level,
    output logic                           stk_full,
    output logic                           stk_empty,
    output logic                           stk_err
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] push_data_s;
    logic              push_s;
    logic              pop_s;
    logic              clr_stk_s;
    logic              err_set_s;
    logic              err_next_s;
    logic              err_r;

    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Op decode: next PC plus stack control; overflow/underflow leave PC alone.
    always_comb begin
        pc_next_s   = pc_r;
        push_data_s = {ADDR_W{1'b0}};
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clr_stk_s   = 1'b0;
        err_set_s   = 1'b0;
        case (pc_op)
            PC_HOLD: pc_next_s = pc_r;
            PC_INC:  pc_next_s = pc_inc_s;
            PC_JMP:  pc_next_s = from_immed;
            PC_CALL: begin
                if (stk_full) begin
                    err_set_s = 1'b1;
                end else begin
                    push_s      = 1'b1;
                    push_data_s = pc_inc_s;
                    pc_next_s   = from_immed;
                end
            end
            PC_RET: begin
                if (stk_empty) begin
                    err_set_s = 1'b1;
                end else begin
                    pop_s     = 1'b1;
                    pc_next_s = stk_top;
                end
            end
            PC_INTR: begin
                if (stk_full) begin
                    err_set_s = 1'b1;
                end else begin
                    push_s      = 1'b1;
                    push_data_s = pc_r;
                    pc_next_s   = INTR_VEC;
                end
            end
            PC_RST: begin
                clr_stk_s = 1'b1;
                pc_next_s = RESET_VEC;
            end
            default: pc_next_s = pc_r;
        endcase
    end

    // A fresh error outranks a simultaneous clear request.
    always_comb begin
        err_next_s = err_r;
        if (err_set_s) begin
            err_next_s = 1'b1;
        end else if (clr_err) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_r;
        end
    end

    // PC and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= RESET_VEC;
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_next_s;
            err_r <= err_next_s;
        end
    end

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .clr   (clr_stk_s),
        .din   (push_data_s),
        .top   (stk_top),
        .level (stk_level),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc_count = pc_r;
    assign stk_err  = err_r;

endmodule
